// File: rtl/sprite_renderer_if.sv
// LCD pixel write channel: coordinate, colour and valid/ready handshake.
// The master (renderer) drives the pixel and valid; the slave (LCD driver) drives ready.
interface sprite_renderer_if;
    logic [7:0]  pixelX;
    logic [8:0]  pixelY;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady;

    modport master (
        output pixelX,
        output pixelY,
        output pixelData,
        output pixelWrite,
        input  pixelReady
    );

    modport slave (
        input  pixelX,
        input  pixelY,
        input  pixelData,
        input  pixelWrite,
        output pixelReady
    );
endinterface

// File: rtl/sprite_renderer.sv
// Sprite renderer: walks one sprite from ROM in raster order and emits a
// pixel write for every opaque pixel that lands on the LT24 screen.
module sprite_renderer #(
    parameter int unsigned SPRITE_W    = 32,
    parameter int unsigned SPRITE_H    = 32,
    parameter int unsigned LCD_W       = 240,
    parameter int unsigned LCD_H       = 320,
    parameter int unsigned NUM_SPRITES = 5,
    parameter logic [15:0] TRANSPARENT = 16'hF81F,
    localparam int unsigned COL_W      = $clog2(SPRITE_W),
    localparam int unsigned ROW_W      = $clog2(SPRITE_H),
    localparam int unsigned ADDR_W     = 4 + ROW_W + COL_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        xSprite,
    input  logic [8:0]        ySprite,
    input  logic [3:0]        spriteId,
    output logic [ADDR_W-1:0] romAddress,
    input  logic [15:0]       romData,
    sprite_renderer_if.master pix,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FETCH   = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] WRITE   = 3'd3;
    localparam logic [2:0] ADVANCE = 3'd4;
    localparam logic [2:0] FINISH  = 3'd5;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPRITE_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPRITE_H - 1);
    localparam logic [9:0]       LCD_W_L  = 10'(LCD_W);
    localparam logic [9:0]       LCD_H_L  = 10'(LCD_H);
    localparam logic [4:0]       NUM_ID_L = 5'(NUM_SPRITES);

    logic [2:0]       state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [7:0]       x_q, x_d;
    logic [8:0]       y_q, y_d;
    logic [3:0]       id_q, id_d;
    logic [7:0]       pix_x_q, pix_x_d;
    logic [8:0]       pix_y_q, pix_y_d;
    logic [15:0]      pix_data_q, pix_data_d;
    logic             pix_wr_q, pix_wr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Screen coordinates are formed 10 bits wide so an origin near the edge
    // plus a column/row offset lands past the screen instead of wrapping to 0.
    logic [9:0] px;
    logic [9:0] py;
    assign px = {2'b00, x_q} + 10'(col_q);
    assign py = {1'b0, y_q} + 10'(row_q);

    // The ROM registers this address on the FETCH edge; data is valid in WAIT.
    assign romAddress     = {id_q, row_q, col_q};
    assign pix.pixelX     = pix_x_q;
    assign pix.pixelY     = pix_y_q;
    assign pix.pixelData  = pix_data_q;
    assign pix.pixelWrite = pix_wr_q;
    assign busy           = busy_q;
    assign done           = done_q;

    // Next-state logic: sequencing of fetch, clip/colour-key test, handshake and raster step.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        x_d        = x_q;
        y_d        = y_q;
        id_d       = id_q;
        pix_x_d    = pix_x_q;
        pix_y_d    = pix_y_q;
        pix_data_d = pix_data_q;
        pix_wr_d   = pix_wr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d    = xSprite;
                    y_d    = ySprite;
                    id_d   = spriteId;
                    row_d  = '0;
                    col_d  = '0;
                    busy_d = 1'b1;
                    if ({1'b0, spriteId} >= NUM_ID_L) begin
                        state_d = FINISH;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                if ((romData != TRANSPARENT) && (px < LCD_W_L) && (py < LCD_H_L)) begin
                    pix_x_d    = px[7:0];
                    pix_y_d    = py[8:0];
                    pix_data_d = romData;
                    pix_wr_d   = 1'b1;
                    state_d    = WRITE;
                end else begin
                    state_d = ADVANCE;
                end
            end
            WRITE: begin
                if (pix.pixelReady) begin
                    pix_wr_d = 1'b0;
                    state_d  = ADVANCE;
                end
            end
            ADVANCE: begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        state_d = FINISH;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = FETCH;
                    end
                end else begin
                    col_d   = col_q + COL_W'(1);
                    state_d = FETCH;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any draw in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            id_q       <= '0;
            pix_x_q    <= '0;
            pix_y_q    <= '0;
            pix_data_q <= '0;
            pix_wr_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            x_q        <= x_d;
            y_q        <= y_d;
            id_q       <= id_d;
            pix_x_q    <= pix_x_d;
            pix_y_q    <= pix_y_d;
            pix_data_q <= pix_data_d;
            pix_wr_q   <= pix_wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: synchronous ROM model, LCD sink with selectable
// ready behaviour, and a per-draw reference list of expected pixel writes.
module tb_sprite_renderer;

    localparam int NS     = 5;
    localparam int TRANSP = 16'hF81F;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  xSprite = '0;
    logic [8:0]  ySprite = '0;
    logic [3:0]  spriteId = '0;
    logic [13:0] romAddress;
    logic [15:0] romData = '0;
    logic        busy;
    logic        done;

    sprite_renderer_if pix_if();

    sprite_renderer #(
        .SPRITE_W(32),
        .SPRITE_H(32),
        .LCD_W(240),
        .LCD_H(320),
        .NUM_SPRITES(NS),
        .TRANSPARENT(16'hF81F)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .xSprite(xSprite),
        .ySprite(ySprite),
        .spriteId(spriteId),
        .romAddress(romAddress),
        .romData(romData),
        .pix(pix_if),
        .busy(busy),
        .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x;
        int y;
        int d;
    } pix_t;

    typedef struct {
        int id;
        int x;
        int y;
        int mode;
        int glitch;
        int exp_writes;
        int exp_cyc;
    } vec_t;

    logic [15:0] rom_mem [0:16383];
    pix_t        cap_q[$];
    pix_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          ready_mode = 0;
    int          bp_cnt = 0;

    // Synchronous sprite ROM: one cycle from address to data.
    always @(posedge clock) romData <= rom_mem[romAddress];

    // LCD ready: 0 = always ready, 1 = random, 2 = stall the first write for 7 cycles.
    always @(posedge clock) begin
        #1;
        if (!busy) bp_cnt = 0;
        case (ready_mode)
            0: pix_if.pixelReady = 1'b1;
            1: pix_if.pixelReady = ($urandom_range(0, 3) != 0);
            default: begin
                if (bp_cnt < 7) begin
                    pix_if.pixelReady = 1'b0;
                    if (pix_if.pixelWrite) bp_cnt++;
                end else begin
                    pix_if.pixelReady = 1'b1;
                end
            end
        endcase
    end

    // LCD sink: record accepted pixels and check that a stalled pixel is held.
    logic        prev_pend = 1'b0;
    logic [7:0]  hx;
    logic [8:0]  hy;
    logic [15:0] hd;
    always @(negedge clock) begin
        pix_t p;
        if (reset) begin
            if (prev_pend) begin
                n_cmp++;
                if (!(pix_if.pixelWrite && pix_if.pixelX == hx && pix_if.pixelY == hy &&
                      pix_if.pixelData == hd)) begin
                    n_err++;
                    $display("FAIL hold_stable: got wr=%0b x=%0d y=%0d d=%h expected wr=1 x=%0d y=%0d d=%h",
                             pix_if.pixelWrite, pix_if.pixelX, pix_if.pixelY, pix_if.pixelData, hx, hy, hd);
                end
            end
            if (pix_if.pixelWrite && pix_if.pixelReady) begin
                p.x = int'(pix_if.pixelX);
                p.y = int'(pix_if.pixelY);
                p.d = int'(pix_if.pixelData);
                cap_q.push_back(p);
            end
            prev_pend = pix_if.pixelWrite && !pix_if.pixelReady;
            hx = pix_if.pixelX;
            hy = pix_if.pixelY;
            hd = pix_if.pixelData;
        end else begin
            prev_pend = 1'b0;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: every sprite pixel in raster order, keeping only opaque on-screen ones.
    function automatic void build_expected(input int id, input int x, input int y);
        pix_t p;
        exp_q.delete();
        if (id >= NS) return;
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                p.x = x + c;
                p.y = y + r;
                p.d = int'(rom_mem[id * 1024 + r * 32 + c]);
                if (p.d != TRANSP && p.x < 240 && p.y < 320) exp_q.push_back(p);
            end
        end
    endfunction

    task automatic run_draw(input int id, input int x, input int y, input int mode,
                            input int exp_cyc, input int glitch, input string tag);
        int n;
        bit got;
        int bad;
        int lim;
        ready_mode = mode;
        build_expected(id, x, y);
        cap_q.delete();
        @(posedge clock); #1;
        spriteId = 4'(id);
        xSprite  = 8'(x);
        ySprite  = 9'(y);
        start    = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        n   = 1;
        got = 1'b0;
        @(negedge clock);
        chk({tag, "_busy_first"}, int'(busy), 1);
        while (!got && n < 20000) begin
            if (done) begin
                got = 1'b1;
            end else begin
                @(posedge clock); #1;
                n++;
                if (glitch != 0 && n == 40) begin
                    start    = 1'b1;
                    xSprite  = ~xSprite;
                    ySprite  = 9'd5;
                    spriteId = 4'd1;
                end
                if (glitch != 0 && n == 41) start = 1'b0;
                @(negedge clock);
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", tag, n);
        end else begin
            if (exp_cyc > 0) chk({tag, "_cycles"}, n, exp_cyc);
            chk({tag, "_busy_at_done"}, int'(busy), 0);
            @(negedge clock);
            chk({tag, "_done_width"}, int'(done), 0);
        end
        chk({tag, "_count_model"}, cap_q.size(), exp_q.size());
        bad = -1;
        lim = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++) begin
            if (bad < 0 && (cap_q[i].x != exp_q[i].x || cap_q[i].y != exp_q[i].y ||
                            cap_q[i].d != exp_q[i].d)) bad = i;
        end
        n_cmp++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s_pixels: write %0d got (%0d,%0d,%h) expected (%0d,%0d,%h)", tag, bad,
                     cap_q[bad].x, cap_q[bad].y, cap_q[bad].d, exp_q[bad].x, exp_q[bad].y, exp_q[bad].d);
        end
    endtask

    vec_t vecs [8];

    initial begin
        // id, x, y, ready mode, start-while-busy, writes, cycles start..done
        vecs[0] = '{0, 10, 20, 0, 0, 1024, 4098};
        vecs[1] = '{1, 50, 60, 0, 0, 1, 3075};
        vecs[2] = '{0, 230, 310, 0, 0, 100, 3174};
        vecs[3] = '{0, 10, 20, 2, 0, 1024, 4105};
        vecs[4] = '{9, 10, 20, 0, 0, 0, 2};
        vecs[5] = '{0, 239, 0, 0, 1, 32, 3106};
        vecs[6] = '{0, 255, 319, 0, 0, 0, 3074};
        vecs[7] = '{5, 0, 0, 0, 0, 0, 2};

        for (int i = 0; i < 16384; i++) begin
            if (i < 1024) rom_mem[i] = 16'h07E0;
            else if (i < 2048) rom_mem[i] = 16'hF81F;
            else if ($urandom_range(0, 3) == 0) rom_mem[i] = 16'hF81F;
            else rom_mem[i] = 16'($urandom);
        end
        rom_mem[1024 + 3 * 32 + 5] = 16'hFFFF;

        #2;
        chk("rst_romAddress", int'(romAddress), 0);
        chk("rst_pixelWrite", int'(pix_if.pixelWrite), 0);
        chk("rst_pixelX", int'(pix_if.pixelX), 0);
        chk("rst_pixelY", int'(pix_if.pixelY), 0);
        chk("rst_pixelData", int'(pix_if.pixelData), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_draw(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].mode, vecs[i].exp_cyc,
                     vecs[i].glitch, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_count_const", i), cap_q.size(), vecs[i].exp_writes);
        end

        for (int k = 0; k < 4; k++) begin
            run_draw(int'($urandom_range(2, 4)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 340)), 1, 0, 0, $sformatf("rand%0d", k));
        end

        // Reset in the middle of a draw, then redraw from the first pixel.
        ready_mode = 0;
        @(posedge clock); #1;
        spriteId = 4'd0;
        xSprite  = 8'd10;
        ySprite  = 9'd20;
        start    = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (300) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        chk("midrst_romAddress", int'(romAddress), 0);
        chk("midrst_pixelWrite", int'(pix_if.pixelWrite), 0);
        chk("midrst_pixelX", int'(pix_if.pixelX), 0);
        chk("midrst_pixelY", int'(pix_if.pixelY), 0);
        chk("midrst_pixelData", int'(pix_if.pixelData), 0);
        chk("midrst_busy", int'(busy), 0);
        repeat (3) begin
            @(negedge clock);
            chk("midrst_no_write", int'(pix_if.pixelWrite), 0);
        end
        @(posedge clock);
        #2 reset = 1'b1;
        run_draw(0, 10, 20, 0, 4098, 0, "redraw");
        chk("redraw_count_const", cap_q.size(), 1024);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
